mem_port_arb: RTL and testbench
===============================

Name: mem_port_arb

Overview:
- Arbitrates one single-ported memory between the instruction-fetch requester (IFU, read-only) and the load/store requester (LSU, read/write).
- Sits between the fetch/execute units and the memory subsystem.
- Grants one requester per cycle and tracks in-flight reads so each read response reaches its owner.
- Raises a hold to the pipeline controller when the LSU is stalled.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte mask width = DATA_W/8)
RD_LAT, 1, memory read latency in cycles, legal 1..4
STARVE_MAX, 4, consecutive IFU-denied cycles before IFU is forced to win, legal 1..15

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ifu_req_i  in  1  fetch request
ifu_addr_i  in  ADDR_W  fetch address
ifu_gnt_o  out  1  fetch request accepted this cycle
ifu_rvalid_o  out  1  fetch data valid
ifu_rdata_o  out  DATA_W  fetch data
lsu_req_i  in  1  load/store request
lsu_we_i  in  1  1 = store
lsu_addr_i  in  ADDR_W  access address
lsu_wdata_i  in  DATA_W  store data
lsu_wmask_i  in  DATA_W/8  byte mask
lsu_gnt_o  out  1  LSU request accepted
lsu_rvalid_o  out  1  load data valid
lsu_rdata_o  out  DATA_W  load data
flush_i  in  1  jump/trap; discard older in-flight fetches
hold_o  out  1  LSU waiting, stall pipeline
mem_req_o  out  1  memory access
mem_we_o  out  1  memory write
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_wmask_o  out  DATA_W/8  memory byte mask
mem_rdata_i  in  DATA_W  memory read data, RD_LAT cycles after read request
conflict_cnt_o  out  32  cycles with both requesters active (optional feature)
starve_cnt_o  out  32  forced IFU grants (optional feature)

Behaviour:
- Clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset: every output is 0, the starvation counter is 0, the in-flight tracker is cleared. A reset asserted mid-operation drops all pending responses; no rvalid follows the reset.
- Grant (combinational, same cycle):
  - Default priority: LSU over IFU.
  - When starve_cnt == STARVE_MAX and both requesters are active, IFU wins.
  - gnt is asserted only when the matching req is asserted.
  - mem_* outputs are muxed from the winner. mem_req_o = ifu_req_i | lsu_req_i.
  - IFU accesses always drive mem_we_o = 0 and wmask = 0.
- Starvation counter:
  - Increments, saturating at STARVE_MAX, on each cycle with ifu_req_i && !ifu_gnt_o.
  - Clears on ifu_gnt_o.
- hold_o = lsu_req_i & ~lsu_gnt_o, combinational.
- In-flight tracker:
  - RD_LAT-deep shift register; each entry holds {valid, owner}.
  - Each granted read pushes {1, owner}; writes and idle cycles push {0, x}.
  - The entry at depth RD_LAT drives the matching rvalid with rdata = mem_rdata_i.
  - Stores produce no rvalid.
  - Both rdata outputs carry mem_rdata_i; only rvalid qualifies them.
- Flush:
  - flush_i clears the valid bit of every IFU entry already in the tracker.
  - An IFU grant in the same cycle as flush_i is retained, because it carries the new PC.
  - LSU entries are never killed.
- Throughput: one access per cycle, back-to-back with no bubbles. Reads are pipelined up to RD_LAT outstanding.

Optional Feature:
MEM_ARB_PERF_EN:
- Defined: conflict_cnt_o increments on every cycle with ifu_req_i && lsu_req_i. starve_cnt_o increments on every IFU grant forced by starvation. Both are 32-bit, wrap at 2^32, and reset to 0.
- Undefined: both ports stay present and are tied to 0; no counter flops exist.

Decomposition:
- Package mem_arb_pkg:
  - owner_e enum (OWN_IFU=0, OWN_LSU=1)
  - inflight_t struct {logic valid; owner_e owner}
  - localparam STARVE_W = 4
- Sub-module mem_arb_rsp_pipe:
  - Parameterised RD_LAT shift register of inflight_t.
  - Flush-kill input, response-routing outputs.

Test Plan:
- Reset, then IFU-only read @0x100 with RD_LAT=1 -> ifu_gnt_o=1 in cycle 0; ifu_rvalid_o=1 in cycle 1 with rdata = mem word; all outputs 0 during reset.
- IFU and LSU both requesting continuously, STARVE_MAX=4 -> LSU granted for cycles 0–3, IFU granted in cycle 4, counter back to 0; hold_o=1 only in cycle 4.
- LSU store 0xDEADBEEF mask 4'b0011 @0x2000, then load of the same address -> mem_we_o=1 with mask 0011 on the store; no lsu_rvalid_o for the store; load returns 0x....BEEF after RD_LAT.
- RD_LAT=3: IFU reads @0x0 and @0x4, flush_i asserted in the cycle of the third IFU grant @0x80 -> only the @0x80 response produces ifu_rvalid_o.
- Interleaved IFU read / LSU read, back-to-back with RD_LAT=2 -> responses are routed to the correct owner in issue order, with no bubbles.
- MEM_ARB_PERF_EN defined, 10 conflict cycles with STARVE_MAX=4 -> conflict_cnt_o=10, starve_cnt_o=2. Undefined -> both read 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: response owner tags, in-flight
// tracker entries and the starvation counter width.
package mem_arb_pkg;

  localparam int STARVE_W = 4;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } inflight_t;

  localparam inflight_t INFLIGHT_NONE = '{valid: 1'b0, owner: OWN_IFU};

  // A flush only kills fetch responses; load responses always complete.
  function automatic inflight_t flush_kill(input inflight_t ent, input logic flush);
    inflight_t res;
    res = ent;
    if (flush && (ent.owner == OWN_IFU)) begin
      res.valid = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_arb_rsp_pipe.sv
// In-flight read tracker: an RD_LAT-deep shift register of owner tags whose
// last stage lines up with the memory's read data and routes it to its owner.
module mem_arb_rsp_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_valid,
  input  owner_e push_owner,
  input  logic   flush_i,
  output logic   ifu_rvalid,
  output logic   lsu_rvalid
);

  inflight_t pipe_q [RD_LAT];
  inflight_t pipe_d [RD_LAT];
  inflight_t push_ent;
  inflight_t head;

  // The entry pushed alongside a flush belongs to the new fetch stream, so
  // it enters stage 0 untouched; everything already in flight is filtered.
  always_comb begin
    push_ent.valid = push_valid;
    push_ent.owner = push_owner;
    pipe_d[0]      = push_ent;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = flush_kill(pipe_q[i-1], flush_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= INFLIGHT_NONE;
      end
    end else begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  // A fetch response emerging in the flush cycle is stale as well.
  assign head       = pipe_q[RD_LAT-1];
  assign ifu_rvalid = head.valid & (head.owner == OWN_IFU) & ~flush_i;
  assign lsu_rvalid = head.valid & (head.owner == OWN_LSU);

endmodule

// File: rtl/mem_port_arb.sv
// Single-port memory arbiter between instruction fetch and load/store, with
// starvation protection for fetch. Optional perf counters: MEM_ARB_PERF_EN.
module mem_port_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_i,
  input  logic [ADDR_W-1:0]   ifu_addr_i,
  output logic                ifu_gnt_o,
  output logic                ifu_rvalid_o,
  output logic [DATA_W-1:0]   ifu_rdata_o,
  input  logic                lsu_req_i,
  input  logic                lsu_we_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_wmask_i,
  output logic                lsu_gnt_o,
  output logic                lsu_rvalid_o,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  input  logic                flush_i,
  output logic                hold_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic [31:0]         conflict_cnt_o,
  output logic [31:0]         starve_cnt_o
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  // Handshake: a requester holds req with a stable payload until it sees gnt
  // in the same cycle; gnt means the access goes to memory this cycle. Read
  // responses return as a one-cycle rvalid pulse with no backpressure.

  logic [STARVE_W-1:0] starve_q;
  logic                both_req;
  logic                force_ifu;
  logic                ifu_win;
  logic                lsu_win;
  logic                push_valid;
  owner_e              push_owner;
  logic                ifu_rvalid;
  logic                lsu_rvalid;

  assign both_req  = ifu_req_i & lsu_req_i;
  assign force_ifu = both_req & (starve_q == STARVE_LIM);
  assign ifu_win   = ifu_req_i & (~lsu_req_i | force_ifu);
  assign lsu_win   = lsu_req_i & ~force_ifu;

  // Outputs are held at zero while reset is asserted, even with live requests.
  assign ifu_gnt_o = rst_n & ifu_win;
  assign lsu_gnt_o = rst_n & lsu_win;
  assign hold_o    = rst_n & lsu_req_i & ~lsu_win;
  assign mem_req_o = rst_n & (ifu_req_i | lsu_req_i);

  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    if (rst_n && ifu_win) begin
      mem_addr_o = ifu_addr_i;
    end else if (rst_n && lsu_win) begin
      mem_we_o    = lsu_we_i;
      mem_addr_o  = lsu_addr_i;
      mem_wdata_o = lsu_wdata_i;
      mem_wmask_o = lsu_wmask_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (ifu_win) begin
      starve_q <= '0;
    end else if (ifu_req_i && (starve_q != STARVE_LIM)) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  assign push_valid = ifu_win | (lsu_win & ~lsu_we_i);
  assign push_owner = lsu_win ? OWN_LSU : OWN_IFU;

  mem_arb_rsp_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rsp_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (push_valid),
    .push_owner (push_owner),
    .flush_i    (flush_i),
    .ifu_rvalid (ifu_rvalid),
    .lsu_rvalid (lsu_rvalid)
  );

  assign ifu_rvalid_o = rst_n & ifu_rvalid;
  assign lsu_rvalid_o = rst_n & lsu_rvalid;
  assign ifu_rdata_o  = rst_n ? mem_rdata_i : '0;
  assign lsu_rdata_o  = rst_n ? mem_rdata_i : '0;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] conflict_q;
  logic [31:0] forced_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= '0;
      forced_q   <= '0;
    end else begin
      if (both_req) begin
        conflict_q <= conflict_q + 32'd1;
      end
      if (force_ifu) begin
        forced_q <= forced_q + 32'd1;
      end
    end
  end

  assign conflict_cnt_o = conflict_q;
  assign starve_cnt_o   = forced_q;
`else
  assign conflict_cnt_o = '0;
  assign starve_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: three instances (RD_LAT 1, 2, 3) share the
// same requester stimulus, each with its own behavioural memory.
module tb_mem_port_arb;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        ifu_req, lsu_req, lsu_we, flush;
  logic [31:0] ifu_addr, lsu_addr, lsu_wdata;
  logic [3:0]  lsu_wmask;

  logic        ifu_gnt [N];
  logic        ifu_rvalid [N];
  logic        lsu_gnt [N];
  logic        lsu_rvalid [N];
  logic        hold [N];
  logic        mem_req [N];
  logic        mem_we [N];
  logic [31:0] ifu_rdata [N];
  logic [31:0] lsu_rdata [N];
  logic [31:0] mem_addr [N];
  logic [31:0] mem_wdata [N];
  logic [31:0] mem_rdata [N];
  logic [31:0] conflict_cnt [N];
  logic [31:0] starve_cnt [N];
  logic [3:0]  mem_wmask [N];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [31:0] store [logic [31:0]];
    logic [31:0] dly [g+1];
    logic [31:0] wr_word;

    // Unwritten words read back as C0DE_xxxx with the low address half.
    function automatic logic [31:0] rd(input logic [31:0] a);
      if (store.exists(a)) return store[a];
      return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    mem_port_arb #(
      .ADDR_W(32), .DATA_W(32), .RD_LAT(g + 1), .STARVE_MAX(4)
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ifu_req_i      (ifu_req),
      .ifu_addr_i     (ifu_addr),
      .ifu_gnt_o      (ifu_gnt[g]),
      .ifu_rvalid_o   (ifu_rvalid[g]),
      .ifu_rdata_o    (ifu_rdata[g]),
      .lsu_req_i      (lsu_req),
      .lsu_we_i       (lsu_we),
      .lsu_addr_i     (lsu_addr),
      .lsu_wdata_i    (lsu_wdata),
      .lsu_wmask_i    (lsu_wmask),
      .lsu_gnt_o      (lsu_gnt[g]),
      .lsu_rvalid_o   (lsu_rvalid[g]),
      .lsu_rdata_o    (lsu_rdata[g]),
      .flush_i        (flush),
      .hold_o         (hold[g]),
      .mem_req_o      (mem_req[g]),
      .mem_we_o       (mem_we[g]),
      .mem_addr_o     (mem_addr[g]),
      .mem_wdata_o    (mem_wdata[g]),
      .mem_wmask_o    (mem_wmask[g]),
      .mem_rdata_i    (mem_rdata[g]),
      .conflict_cnt_o (conflict_cnt[g]),
      .starve_cnt_o   (starve_cnt[g])
    );

    always @(posedge clk) begin
      if (mem_req[g] && mem_we[g]) begin
        wr_word = rd(mem_addr[g]);
        for (int b = 0; b < 4; b++) begin
          if (mem_wmask[g][b]) wr_word[8*b +: 8] = mem_wdata[g][8*b +: 8];
        end
        store[mem_addr[g]] = wr_word;
      end
      dly[0] <= rd(mem_addr[g]);
      for (int i = 1; i < g + 1; i++) dly[i] <= dly[i-1];
    end

    assign mem_rdata[g] = dly[g];
  end

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        lr;
    logic        lw;
    logic [31:0] la;
    logic [31:0] ld;
    logic [3:0]  lm;
    logic        e_ig;
    logic        e_lg;
    logic        e_hold;
    logic        e_mreq;
    logic        e_mwe;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
    logic [3:0]  e_mmask;
    logic        e_irv;
    logic        e_lrv;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs [12];

  // Flush / LSU-survival sequence on the RD_LAT=3 instance.
  int          f_ir  [12] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  logic [31:0] f_ia  [12] = '{32'h0, 32'h4, 32'h80, 32'h0, 32'h0, 32'h0,
                              32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  int          f_lr  [12] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
  int          f_fl  [12] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
  int          f_irv [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
  int          f_lrv [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

  // Interleaved sequence on the RD_LAT=2 instance.
  int          i_ir  [6] = '{1, 0, 1, 0, 0, 0};
  int          i_lr  [6] = '{0, 1, 0, 1, 0, 0};
  logic [31:0] i_a   [6] = '{32'h10, 32'h20, 32'h14, 32'h24, 32'h0, 32'h0};
  int          i_irv [6] = '{0, 0, 1, 0, 1, 0};
  int          i_lrv [6] = '{0, 0, 0, 1, 0, 1};
  logic [31:0] i_rd  [6] = '{32'h0, 32'h0, 32'hC0DE0010, 32'hC0DE0020,
                             32'hC0DE0014, 32'hC0DE0024};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic ir, input logic [31:0] ia, input logic lr,
                        input logic lw, input logic [31:0] la, input logic [31:0] ld,
                        input logic [3:0] lm, input logic fl);
    ifu_req   = ir;
    ifu_addr  = ia;
    lsu_req   = lr;
    lsu_we    = lw;
    lsu_addr  = la;
    lsu_wdata = ld;
    lsu_wmask = lm;
    flush     = fl;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1ns after a rising edge with reset released: cycle 0.
  task automatic do_reset();
    rst_n = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    next_cyc();
    next_cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [31:0] exp_conf;
    logic [31:0] exp_forced;

    vecs[0]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'h3,
                 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'h3, 1'b1, 1'b0, 32'hC0DE0100};
    vecs[3]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h2000, 32'h0, 4'h0,
                 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h2000, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 32'h200, 1'b1, 1'b0, 32'h3000, 32'h0, 4'h0,
                 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h3000, 32'h0, 4'h0, 1'b0, 1'b1, 32'hC0DEBEEF};
    for (int i = 5; i < 8; i++) begin
      vecs[i]  = '{1'b1, 32'h200, 1'b1, 1'b0, 32'h3000, 32'h0, 4'h0,
                   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h3000, 32'h0, 4'h0, 1'b0, 1'b1, 32'hC0DE3000};
    end
    vecs[8]  = '{1'b1, 32'h200, 1'b1, 1'b1, 32'h3000, 32'h12345678, 4'hF,
                 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 1'b0, 1'b1, 32'hC0DE3000};
    vecs[9]  = '{1'b1, 32'h200, 1'b1, 1'b0, 32'h3000, 32'h0, 4'h0,
                 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h3000, 32'h0, 4'h0, 1'b1, 1'b0, 32'hC0DE0200};
    vecs[10] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'hC0DE3000};
    vecs[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0};

    // Reset: every output is zero, even with both requesters asserting.
    rst_n = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    repeat (2) @(negedge clk);
    set_in(1'b1, 32'h100, 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'hF, 1'b0);
    #1;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst_ifu_gnt%0d", k), ifu_gnt[k], 32'h0);
      chk($sformatf("rst_lsu_gnt%0d", k), lsu_gnt[k], 32'h0);
      chk($sformatf("rst_ifu_rv%0d", k), ifu_rvalid[k], 32'h0);
      chk($sformatf("rst_lsu_rv%0d", k), lsu_rvalid[k], 32'h0);
      chk($sformatf("rst_ifu_rdata%0d", k), ifu_rdata[k], 32'h0);
      chk($sformatf("rst_lsu_rdata%0d", k), lsu_rdata[k], 32'h0);
      chk($sformatf("rst_hold%0d", k), hold[k], 32'h0);
      chk($sformatf("rst_mem_req%0d", k), mem_req[k], 32'h0);
      chk($sformatf("rst_mem_we%0d", k), mem_we[k], 32'h0);
      chk($sformatf("rst_mem_addr%0d", k), mem_addr[k], 32'h0);
      chk($sformatf("rst_mem_wdata%0d", k), mem_wdata[k], 32'h0);
      chk($sformatf("rst_mem_wmask%0d", k), {28'h0, mem_wmask[k]}, 32'h0);
      chk($sformatf("rst_conflict%0d", k), conflict_cnt[k], 32'h0);
      chk($sformatf("rst_starve%0d", k), starve_cnt[k], 32'h0);
    end

    // Table: grant/mux/starvation/store-load on the RD_LAT=1 instance.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].ir, vecs[i].ia, vecs[i].lr, vecs[i].lw, vecs[i].la,
             vecs[i].ld, vecs[i].lm, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d_ifu_gnt", i), ifu_gnt[0], vecs[i].e_ig);
      chk($sformatf("v%0d_lsu_gnt", i), lsu_gnt[0], vecs[i].e_lg);
      chk($sformatf("v%0d_hold", i), hold[0], vecs[i].e_hold);
      chk($sformatf("v%0d_mem_req", i), mem_req[0], vecs[i].e_mreq);
      chk($sformatf("v%0d_mem_we", i), mem_we[0], vecs[i].e_mwe);
      chk($sformatf("v%0d_mem_addr", i), mem_addr[0], vecs[i].e_maddr);
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata[0], vecs[i].e_mwdata);
      chk($sformatf("v%0d_mem_wmask", i), {28'h0, mem_wmask[0]}, {28'h0, vecs[i].e_mmask});
      chk($sformatf("v%0d_ifu_rv", i), ifu_rvalid[0], vecs[i].e_irv);
      chk($sformatf("v%0d_lsu_rv", i), lsu_rvalid[0], vecs[i].e_lrv);
      if (vecs[i].e_irv) chk($sformatf("v%0d_ifu_rdata", i), ifu_rdata[0], vecs[i].e_rdata);
      if (vecs[i].e_lrv) chk($sformatf("v%0d_lsu_rdata", i), lsu_rdata[0], vecs[i].e_rdata);
      next_cyc();
    end

    // Flush kills older fetches but keeps the fetch granted with it and loads.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      set_in(f_ir[c] != 0, f_ia[c], f_lr[c] != 0, 1'b0, 32'h44, 32'h0, 4'h0, f_fl[c] != 0);
      @(negedge clk);
      if (f_ir[c] != 0) chk($sformatf("fl%0d_ifu_gnt", c), ifu_gnt[2], 32'h1);
      chk($sformatf("fl%0d_ifu_rv", c), ifu_rvalid[2], f_irv[c]);
      chk($sformatf("fl%0d_lsu_rv", c), lsu_rvalid[2], f_lrv[c]);
      if (f_irv[c] != 0) chk($sformatf("fl%0d_ifu_rdata", c), ifu_rdata[2], 32'hC0DE0080);
      if (f_lrv[c] != 0) chk($sformatf("fl%0d_lsu_rdata", c), lsu_rdata[2], 32'hC0DE0044);
      next_cyc();
    end

    // Back-to-back alternating owners on the RD_LAT=2 instance.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      set_in(i_ir[c] != 0, i_a[c], i_lr[c] != 0, 1'b0, i_a[c], 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      chk($sformatf("il%0d_ifu_gnt", c), ifu_gnt[1], i_ir[c]);
      chk($sformatf("il%0d_lsu_gnt", c), lsu_gnt[1], i_lr[c]);
      chk($sformatf("il%0d_ifu_rv", c), ifu_rvalid[1], i_irv[c]);
      chk($sformatf("il%0d_lsu_rv", c), lsu_rvalid[1], i_lrv[c]);
      if (i_irv[c] != 0) chk($sformatf("il%0d_ifu_rdata", c), ifu_rdata[1], i_rd[c]);
      if (i_lrv[c] != 0) chk($sformatf("il%0d_lsu_rdata", c), lsu_rdata[1], i_rd[c]);
      next_cyc();
    end

    // Ten conflict cycles: IFU is forced through in cycles 4 and 9.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      set_in(1'b1, 32'h400, 1'b1, 1'b0, 32'h500, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      chk($sformatf("pf%0d_ifu_gnt", c), ifu_gnt[0], (c == 4 || c == 9) ? 32'h1 : 32'h0);
      chk($sformatf("pf%0d_hold", c), hold[0], (c == 4 || c == 9) ? 32'h1 : 32'h0);
      next_cyc();
    end
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
`ifdef MEM_ARB_PERF_EN
    exp_conf   = 32'd10;
    exp_forced = 32'd2;
`else
    exp_conf   = 32'd0;
    exp_forced = 32'd0;
`endif
    chk("perf_conflict", conflict_cnt[0], exp_conf);
    chk("perf_starve", starve_cnt[0], exp_forced);
    next_cyc();

    // Reset during an outstanding read: its response never appears.
    do_reset();
    set_in(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    chk("mr_ifu_gnt", ifu_gnt[2], 32'h1);
    next_cyc();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_rv_in_reset", ifu_rvalid[0], 32'h0);
    next_cyc();
    rst_n = 1'b1;
    for (int c = 2; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("mr%0d_ifu_rv_lat3", c), ifu_rvalid[2], 32'h0);
      chk($sformatf("mr%0d_ifu_rv_lat2", c), ifu_rvalid[1], 32'h0);
      next_cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
